// File: rtl/dnn_deint_pkg.sv
// Shared types, width helpers and the saturating add for deinterleave_accum.
// Saturation is only used when DEINT_SAT_EN is defined.
package dnn_deint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Never returns 0 so degenerate sizes still give a legal vector.
  function automatic int wclog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int row_w(input int p, input int z);
    return wclog2(p / z);
  endfunction

  function automatic int chunk_w(input int p, input int z);
    return wclog2(p / z);
  endfunction

  function automatic int cyc_w(input int fo, input int p, input int z);
    return wclog2(fo * p / z);
  endfunction

  function automatic int ssa_w(input int fo, input int z);
    return wclog2(fo * z);
  endfunction

  // a + b clamped to the signed range of an aw-bit value (aw <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int aw);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/deint_lane.sv
// One lane of deinterleave_accum: p/z accumulators with add, clear and
// combinational read. Adds saturate when DEINT_SAT_EN is defined, else wrap.
module deint_lane
  import dnn_deint_pkg::*;
#(
  parameter int p  = 32,
  parameter int z  = 8,
  parameter int W  = 16,
  parameter int AW = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   add_en,
  input  logic [row_w(p,z)-1:0]  add_row,
  input  logic [W-1:0]           add_data,
  input  logic                   clr_en,
  input  logic [row_w(p,z)-1:0]  clr_row,
  input  logic [row_w(p,z)-1:0]  rd_row,
  output logic [AW-1:0]          rd_data
);

  localparam int ROWS = p / z;

  logic [AW-1:0]        acc [ROWS];
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] sum;

  always_comb begin
    ext = AW'($signed(add_data));
`ifdef DEINT_SAT_EN
    sum = AW'(sat_add(64'($signed(acc[add_row])), 64'(ext), AW));
`else
    sum = $signed(acc[add_row]) + ext;
`endif
  end

  // Adds happen only in ACCUM and clears only in DRAIN, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) acc[i] <= '0;
    end else begin
      if (add_en) acc[add_row] <= sum;
      if (clr_en) acc[clr_row] <= '0;
    end
  end

  assign rd_data = acc[rd_row];

endmodule

// File: rtl/deinterleave_accum.sv
// Backward-path deinterleaving accumulator: scatters z lane values per beat into
// per-neuron sums, then drains one row of z sums per beat. Option: DEINT_SAT_EN.
module deinterleave_accum
  import dnn_deint_pkg::*;
#(
  parameter int fo = 2,
  parameter int p  = 32,
  parameter int z  = 8,
  parameter int W  = 16,
  parameter int AW = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ss_wr_en,
  input  logic [ssa_w(fo,z)-1:0]    ss_wr_addr,
  input  logic [chunk_w(p,z)-1:0]   ss_wr_data,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W*z-1:0]            in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [row_w(p,z)-1:0]     out_row,
  output logic [AW*z-1:0]           out_data,
  output logic                      busy,
  output logic                      done
);

  localparam int ROWS  = p / z;
  localparam int BEATS = fo * ROWS;
  localparam int RW    = row_w(p, z);
  localparam int CW    = cyc_w(fo, p, z);
  localparam int SAW   = ssa_w(fo, z);

  state_t              state, state_nx;
  logic [CW-1:0]       c;
  logic [RW-1:0]       r;
  logic [RW-1:0]       ss [fo*z];
  logic [CW-1:0]       sweep;
  logic [RW-1:0]       k;
  logic                beat, pop, last_beat, last_row;
  logic [z-1:0][RW-1:0] rows;
  logic [z-1:0][AW-1:0] rd;

  assign beat      = (state == ST_ACCUM) && in_valid;
  assign pop       = (state == ST_DRAIN) && out_ready;
  assign last_beat = (c == CW'(BEATS - 1));
  assign last_row  = (r == RW'(ROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start)                 state_nx = ST_ACCUM;
      ST_ACCUM: if (beat && last_beat)     state_nx = ST_DRAIN;
      ST_DRAIN: if (pop && last_row)       state_nx = ST_IDLE;
      default:                             state_nx = ST_IDLE;
    endcase
  end

  // BEATS and ROWS are powers of two, so c and r wrap to 0 on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c <= '0;
      r <= '0;
    end else begin
      if (state == ST_IDLE && start) c <= '0;
      else if (beat)                 c <= c + 1'b1;
      if (pop)                       r <= r + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < fo*z; i++) ss[i] <= '0;
    end else if (state == ST_IDLE && ss_wr_en) begin
      ss[ss_wr_addr] <= ss_wr_data;
    end
  end

  assign sweep = c >> RW;
  assign k     = c[RW-1:0];

  for (genvar g = 0; g < z; g++) begin : g_lane
    // Row wraps modulo p/z through the natural RW-bit add.
    assign rows[g] = ss[SAW'(sweep * z + g)] + k;

    deint_lane #(.p(p), .z(z), .W(W), .AW(AW)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .add_en   (beat),
      .add_row  (rows[g]),
      .add_data (in_data[W*g +: W]),
      .clr_en   (pop),
      .clr_row  (r),
      .rd_row   (r),
      .rd_data  (rd[g])
    );
  end

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign done      = pop && last_row;
  assign out_row   = r;
  assign out_data  = (state == ST_DRAIN) ? rd : '0;

endmodule

// File: tb/tb_deinterleave_accum.sv
// Directed bench for deinterleave_accum (p=8, z=4, fo=2, W=16); a second
// instance with AW=16 covers wrap/saturation depending on DEINT_SAT_EN.
module tb_deinterleave_accum;

  logic        clk, reset;
  logic        ss_wr_en;
  logic [2:0]  ss_wr_addr;
  logic [0:0]  ss_wr_data;
  logic        start, in_valid, out_ready;
  logic [63:0] in_data;

  logic        in_ready, out_valid, busy, done;
  logic [0:0]  out_row;
  logic [95:0] out_data;

  logic        s_in_ready, s_out_valid, s_busy, s_done;
  logic [0:0]  s_out_row;
  logic [63:0] s_out_data;

  int errors = 0;
  int checks = 0;

  logic [95:0] got   [2];
  logic [63:0] sgot  [2];
  logic [0:0]  got_row [2];
  int          n_rows, n_dones;

  deinterleave_accum #(.fo(2), .p(8), .z(4), .W(16), .AW(24)) dut (
    .clk(clk), .reset(reset), .ss_wr_en(ss_wr_en), .ss_wr_addr(ss_wr_addr),
    .ss_wr_data(ss_wr_data), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
    .busy(busy), .done(done)
  );

  deinterleave_accum #(.fo(2), .p(8), .z(4), .W(16), .AW(16)) dut_s (
    .clk(clk), .reset(reset), .ss_wr_en(ss_wr_en), .ss_wr_addr(ss_wr_addr),
    .ss_wr_data(ss_wr_data), .start(start), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_row(s_out_row), .out_data(s_out_data),
    .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic ss_write(input logic [2:0] a, input logic [0:0] d);
    ss_wr_en = 1'b1; ss_wr_addr = a; ss_wr_data = d;
    tick();
    ss_wr_en = 1'b0; ss_wr_addr = '0; ss_wr_data = '0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0; in_data = '0;
  endtask

  // Drains both instances in lockstep; results go to got/sgot/got_row.
  task automatic drain_all;
    int n;
    n = 0; n_rows = 0; n_dones = 0;
    out_ready = 1'b1;
    while (n_rows < 2 && n < 50) begin
      if (out_valid) begin
        got[n_rows] = out_data; sgot[n_rows] = s_out_data;
        got_row[n_rows] = out_row;
        if (done) n_dones++;
        n_rows++;
      end
      tick();
      n++;
    end
    if (done) n_dones++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_valid_done got=%b%b exp=00", out_valid, done); end
    checks++; if (out_row !== 1'b0 || out_data !== 96'd0) begin errors++; $display("FAIL reset_out got=%h/%h exp=0/0", out_row, out_data); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_baseline;
    do_start();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL base_start got=%b%b exp=11", in_ready, busy); end
    for (int b = 0; b < 4; b++) send_beat({4{16'd1}});
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL base_drain_enter got=%b%b exp=10", out_valid, in_ready); end
    drain_all();
    checks++; if (n_rows !== 2) begin errors++; $display("FAIL base_rows got=%0d exp=2", n_rows); end
    checks++; if (got_row[0] !== 1'b0 || got_row[1] !== 1'b1) begin errors++; $display("FAIL base_order got=%b%b exp=01", got_row[0], got_row[1]); end
    checks++; if (got[0] !== {4{24'd2}}) begin errors++; $display("FAIL base_row0 got=%h exp=%h", got[0], {4{24'd2}}); end
    checks++; if (got[1] !== {4{24'd2}}) begin errors++; $display("FAIL base_row1 got=%h exp=%h", got[1], {4{24'd2}}); end
    checks++; if (n_dones !== 1) begin errors++; $display("FAIL base_done got=%0d exp=1", n_dones); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL base_idle got=%b exp=0", busy); end
  endtask

  task automatic test_mapping;
    ss_write(3'd0, 1'b1);
    do_start();
    send_beat(64'd5);
    for (int b = 1; b < 4; b++) send_beat(64'd0);
    drain_all();
    checks++; if (got[0] !== 96'd0) begin errors++; $display("FAIL map_row0 got=%h exp=0", got[0]); end
    checks++; if (got[1] !== 96'd5) begin errors++; $display("FAIL map_row1 got=%h exp=5", got[1]); end
  endtask

  task automatic test_gated_writes;
    do_start();
    ss_write(3'd0, 1'b0);
    for (int b = 0; b < 4; b++) send_beat(64'd0);
    drain_all();
    checks++; if (got[0] !== 96'd0 || got[1] !== 96'd0) begin errors++; $display("FAIL gate_zero got=%h/%h exp=0/0", got[0], got[1]); end
    do_start();
    send_beat(64'd5);
    for (int b = 1; b < 4; b++) send_beat(64'd0);
    drain_all();
    checks++; if (got[0] !== 96'd0 || got[1] !== 96'd5) begin errors++; $display("FAIL gate_old_ss got=%h/%h exp=0/5", got[0], got[1]); end
  endtask

  task automatic test_saturation;
    logic [15:0] exp_s;
`ifdef DEINT_SAT_EN
    exp_s = 16'h7FFF;
`else
    exp_s = 16'hFFFE;
`endif
    do_reset();
    do_start();
    for (int b = 0; b < 4; b++) send_beat(64'h7FFF);
    drain_all();
    checks++; if (sgot[0] !== {48'd0, exp_s}) begin errors++; $display("FAIL sat_row0 got=%h exp=%h", sgot[0], {48'd0, exp_s}); end
    checks++; if (sgot[1] !== {48'd0, exp_s}) begin errors++; $display("FAIL sat_row1 got=%h exp=%h", sgot[1], {48'd0, exp_s}); end
    checks++; if (got[0] !== 96'd65534) begin errors++; $display("FAIL wide_row0 got=%h exp=%h", got[0], 96'd65534); end
  endtask

  task automatic test_backpressure;
    logic [95:0] held;
    do_start();
    for (int b = 0; b < 4; b++) send_beat({16'd4, 16'd3, 16'd2, 16'd1});
    out_ready = 1'b0;
    held = {24'd8, 24'd6, 24'd4, 24'd2};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== 1'b0 || out_data !== held || done !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%b/%h/%b exp=1/0/%h/0", i, out_valid, out_row, out_data, done, held);
      end
      tick();
    end
    drain_all();
    checks++; if (got_row[0] !== 1'b0 || got_row[1] !== 1'b1) begin errors++; $display("FAIL bp_order got=%b%b exp=01", got_row[0], got_row[1]); end
    checks++; if (got[0] !== held || got[1] !== held) begin errors++; $display("FAIL bp_data got=%h/%h exp=%h", got[0], got[1], held); end
    checks++; if (n_dones !== 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", n_dones); end
  endtask

  task automatic test_reset_mid;
    do_start();
    send_beat({4{16'd9}});
    send_beat({4{16'd9}});
    reset = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid got=%b%b exp=00", busy, in_ready); end
    tick();
    reset = 1'b0;
    tick();
    do_start();
    for (int b = 0; b < 4; b++) send_beat({4{16'd1}});
    drain_all();
    checks++; if (got[0] !== {4{24'd2}} || got[1] !== {4{24'd2}}) begin errors++; $display("FAIL rst_residue got=%h/%h exp=%h", got[0], got[1], {4{24'd2}}); end
  endtask

  initial begin
    reset = 1'b0; ss_wr_en = 1'b0; ss_wr_addr = '0; ss_wr_data = '0;
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_baseline();
    test_mapping();
    test_gated_writes();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
